cpu_seq_ctrl: RTL and testbench
===============================

Name: cpu_seq_ctrl

Overview:
Multi-cycle control sequencer for the RV64 core datapath (fetch, decode, execute, register file, PC).
- Steps one instruction at a time through FETCH -> DECODE -> EXEC -> WB.
- Owns the PC register and the instruction register. Drives the ALU control code and the register-file write enable.
- Fetches through a simple request/valid instruction-memory handshake.
- Stops on ebreak (halt) or on an illegal instruction or fetch timeout (trap).

Parameters:
XLEN, 64, PC and address width
RESET_PC, 64'h80000000, PC value after reset
TIMEOUT, 16, max cycles in FETCH without imem_valid before trap (>=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  fetch request, high only in FETCH
imem_addr  output  XLEN  fetch address, equals pc_out
imem_valid  input  1  instruction data valid this cycle
imem_rdata  input  32  instruction word
inst  output  32  latched instruction register
pc_out  output  XLEN  current PC
exu_ctr  output  4  ALU control code for the current instruction
regWr  output  1  register-file write enable
state  output  3  FSM state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5, TRAP=6
halt  output  1  sticky, ebreak reached
trap  output  1  sticky, error stop
trap_cause  output  2  0=none, 1=fetch timeout, 2=illegal instruction
retired  output  64  count of instructions completed in WB

Behaviour:
Reset:
- Applies on any cycle in which rst=1, from any state, including mid-fetch.
- Reset values: state=IDLE, pc_out=RESET_PC, inst=0, exu_ctr=0, regWr=0, imem_req=0, halt=0, trap=0, trap_cause=0, retired=0, wait counter=0.
- An in-flight fetch is abandoned: imem_req is 0 in the cycle after the reset edge.

IDLE:
- Lasts one cycle, then goes to FETCH.

FETCH:
- imem_req=1 combinationally; imem_addr=pc_out.
- imem_valid=1 in a FETCH cycle: latch imem_rdata into inst, go to DECODE, clear the wait counter.
- Otherwise the wait counter increments.
- Valid not seen by the TIMEOUT-th FETCH cycle: go to TRAP with cause 1.
- imem_valid in any state other than FETCH is ignored; inst is unchanged.

DECODE (one cycle) classifies inst:
- inst == 32'h00100073 (ebreak): go to HALT.
- opcode 0010011, funct3 000 (addi): exu_ctr=4'b0000.
- opcode 0110011, funct3 000, funct7 0000000 (add): exu_ctr=4'b0000.
- opcode 0110011, funct3 000, funct7 0100000 (sub): exu_ctr=4'b1000.
- opcode 0110111 (lui): exu_ctr=4'b0011 (pass operand B).
- Anything else: go to TRAP with cause 2. pc_out stays at the faulting instruction address.

EXEC:
- One cycle. regWr=0. exu_ctr stable.

WB (one cycle):
- regWr=1 only if inst[11:7] != 0. Writes to x0 suppress regWr.
- pc_out <= pc_out + 4, modulo 2^XLEN (wraps from all-ones-minus-3 to 0).
- retired <= retired + 1, wrapping.
- Next state is FETCH.

HALT / TRAP:
- Absorbing; only rst exits.
- halt or trap=1; imem_req=0; regWr=0; pc_out, inst and retired frozen.
- trap_cause is held.

Output timing and sequencing rules:
- exu_ctr is registered, valid from the DECODE->EXEC edge through WB, and holds its last value elsewhere.
- regWr is high for exactly one cycle per retired non-x0 instruction.
- Throughput: minimum 4 cycles per instruction (FETCH with immediate valid, DECODE, EXEC, WB).
- halt and trap are never both 1.
- rst asserted in the same cycle as imem_valid: reset wins; inst stays 0.

Test Plan:
1. Reset, then imem_valid held 1 with rdata=32'h00500093 (addi x1,x0,5) -> FETCH at cycle 1; DECODE, EXEC, WB follow; regWr=1 in WB only; exu_ctr=0; pc_out=64'h80000004; retired=1.
2. Program add(32'h002081b3), sub(32'h402081b3), addi x0(32'h00000013), then imem_valid delayed 3 cycles per fetch -> exu_ctr 0000, 1000, 0000; regWr pulses on the 1st and 2nd only; retired=3; pc_out=64'h8000000C.
3. Fetch ebreak 32'h00100073 -> HALT (state=5); halt=1; imem_req stays 0 for 20 cycles; pc_out unchanged; retired unchanged.
4. Fetch 32'hFFFFFFFF -> TRAP; trap_cause=2; pc_out = fetch address; regWr never asserted.
5. imem_valid held 0 for TIMEOUT=16 cycles in FETCH -> TRAP with cause 1 after the 16th FETCH cycle. Then rst=1 for one cycle -> all reset values; FETCH resumes at RESET_PC.
6. RESET_PC=64'hFFFFFFFFFFFFFFFC, one addi retired -> pc_out wraps to 0. Separately, rst asserted mid-EXEC -> state=IDLE next cycle; regWr never pulses.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control sequencer for the RV64 core datapath.
// Owns the PC and instruction register; stops on ebreak (halt) or on error (trap).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | one-cycle pause after reset before the first fetch
// FETCH  | imem_req high, waiting for imem_valid (bounded by TIMEOUT)
// DECODE | classify inst: legal op, ebreak or illegal
// EXEC   | ALU operates with the registered exu_ctr
// WB     | register write (unless rd=x0), PC += 4, retire count += 1
// HALT   | ebreak reached, absorbing until rst
// TRAP   | fetch timeout or illegal instruction, absorbing until rst
module cpu_seq_ctrl #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned     TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc_out,
  output logic [3:0]      exu_ctr,
  output logic            regWr,
  output logic [2:0]      state,
  output logic            halt,
  output logic            trap,
  output logic [1:0]      trap_cause,
  output logic [63:0]     retired
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [6:0]  OP_IMM   = 7'b0010011;
  localparam logic [6:0]  OP_REG   = 7'b0110011;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  F7_ZERO  = 7'b0000000;
  localparam logic [6:0]  F7_SUB   = 7'b0100000;

  localparam logic [3:0]  CTR_ADD  = 4'b0000;
  localparam logic [3:0]  CTR_SUB  = 4'b1000;
  localparam logic [3:0]  CTR_PASS = 4'b0011;

  localparam logic [1:0]  CAUSE_TIMEOUT = 2'd1;
  localparam logic [1:0]  CAUSE_ILLEGAL = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  wait_cnt;
  logic [XLEN-1:0]   pc_q;
  logic [31:0]       inst_q;
  logic [3:0]        exu_ctr_q;
  logic [63:0]       retired_q;
  logic              halt_q;
  logic              trap_q;
  logic [1:0]        trap_cause_q;

  logic              dec_ebreak;
  logic              dec_legal;
  logic [3:0]        dec_ctr;
  logic              fetch_expired;

  // Instruction classification, evaluated on the latched instruction word.
  always_comb begin
    dec_ebreak = (inst_q == EBREAK);
    dec_legal  = 1'b0;
    dec_ctr    = CTR_ADD;
    case (inst_q[6:0])
      OP_IMM: begin
        dec_legal = (inst_q[14:12] == 3'b000);
      end
      OP_REG: begin
        if (inst_q[14:12] == 3'b000 && inst_q[31:25] == F7_ZERO) begin
          dec_legal = 1'b1;
        end else if (inst_q[14:12] == 3'b000 && inst_q[31:25] == F7_SUB) begin
          dec_legal = 1'b1;
          dec_ctr   = CTR_SUB;
        end
      end
      OP_LUI: begin
        dec_legal = 1'b1;
        dec_ctr   = CTR_PASS;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  assign fetch_expired = !imem_valid && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (imem_valid) begin
          state_d = S_DECODE;
        end else if (fetch_expired) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        if (dec_ebreak) begin
          state_d = S_HALT;
        end else if (!dec_legal) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state_q == S_FETCH);
    regWr    = (state_q == S_WB) && (inst_q[11:7] != 5'd0);
  end

  // Datapath registers; only the states listed here change anything.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt     <= '0;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      exu_ctr_q    <= '0;
      retired_q    <= '0;
      halt_q       <= 1'b0;
      trap_q       <= 1'b0;
      trap_cause_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_valid) begin
            inst_q   <= imem_rdata;
            wait_cnt <= '0;
          end else if (fetch_expired) begin
            wait_cnt     <= '0;
            trap_q       <= 1'b1;
            trap_cause_q <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          if (dec_ebreak) begin
            halt_q <= 1'b1;
          end else if (!dec_legal) begin
            trap_q       <= 1'b1;
            trap_cause_q <= CAUSE_ILLEGAL;
          end else begin
            exu_ctr_q <= dec_ctr;
          end
        end
        S_WB: begin
          pc_q      <= pc_q + XLEN'(4);
          retired_q <= retired_q + 64'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign state      = state_q;
  assign pc_out     = pc_q;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign exu_ctr    = exu_ctr_q;
  assign retired    = retired_q;
  assign halt       = halt_q;
  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed and randomized bench for cpu_seq_ctrl against an instruction-level model.
// A second instance with RESET_PC near the top of the address space shares all inputs.
module tb_cpu_seq_ctrl;

  localparam int          TIMEOUT = 16;
  localparam logic [63:0] RPC     = 64'h0000_0000_8000_0000;
  localparam logic [63:0] RPC_W   = 64'hFFFF_FFFF_FFFF_FFFC;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;

  logic        imem_req, regWr, halt, trap;
  logic [63:0] imem_addr, pc_out, retired;
  logic [31:0] inst;
  logic [3:0]  exu_ctr;
  logic [2:0]  state;
  logic [1:0]  trap_cause;

  logic        imem_req_w, regWr_w, halt_w, trap_w;
  logic [63:0] imem_addr_w, pc_out_w, retired_w;
  logic [31:0] inst_w;
  logic [3:0]  exu_ctr_w;
  logic [2:0]  state_w;
  logic [1:0]  trap_cause_w;

  cpu_seq_ctrl #(.XLEN(64), .RESET_PC(RPC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .inst(inst), .pc_out(pc_out),
    .exu_ctr(exu_ctr), .regWr(regWr), .state(state), .halt(halt), .trap(trap),
    .trap_cause(trap_cause), .retired(retired)
  );

  cpu_seq_ctrl #(.XLEN(64), .RESET_PC(RPC_W), .TIMEOUT(TIMEOUT)) dut_w (
    .clk(clk), .rst(rst), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .inst(inst_w), .pc_out(pc_out_w),
    .exu_ctr(exu_ctr_w), .regWr(regWr_w), .state(state_w), .halt(halt_w), .trap(trap_w),
    .trap_cause(trap_cause_w), .retired(retired_w)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Architectural model: values the outputs must show at any point in time.
  logic [63:0] m_pc;
  logic [63:0] m_retired;
  logic [31:0] m_inst;
  logic [3:0]  m_ctr;
  logic        m_halt;
  logic        m_trap;
  logic [1:0]  m_cause;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic noise();
    imem_valid = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
  endtask

  function automatic void classify(input logic [31:0] w, output int kind, output logic [3:0] ctr);
    // kind: 0 = retires, 1 = ebreak, 2 = illegal
    kind = 2;
    ctr  = 4'b0000;
    if (w == 32'h0010_0073) kind = 1;
    else if (w[6:0] == 7'b0010011 && w[14:12] == 3'b000) kind = 0;
    else if (w[6:0] == 7'b0110011 && w[14:12] == 3'b000 && w[31:25] == 7'b0000000) kind = 0;
    else if (w[6:0] == 7'b0110011 && w[14:12] == 3'b000 && w[31:25] == 7'b0100000) begin
      kind = 0;
      ctr  = 4'b1000;
    end else if (w[6:0] == 7'b0110111) begin
      kind = 0;
      ctr  = 4'b0011;
    end
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] r;
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    r   = $urandom;
    if ($urandom_range(0, 4) == 0) rd = 5'd0;
    case ($urandom_range(0, 7))
      0, 1:    return {r[31:20], rs1, 3'b000, rd, 7'b0010011};
      2:       return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      3:       return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      4:       return {r[31:12], rd, 7'b0110111};
      5:       return 32'h0010_0073;
      6:       return {r[31:25], rs2, rs1, r[14:12], rd, 7'b0110011};
      default: return r;
    endcase
  endfunction

  task automatic check_all(input logic [2:0] st);
    logic exp_wr;
    exp_wr = (st == S_WB) && (m_inst[11:7] != 5'd0);
    chk("state",      64'(state),      64'(st));
    chk("imem_req",   64'(imem_req),   64'(st == S_FETCH));
    chk("imem_addr",  imem_addr,       m_pc);
    chk("pc_out",     pc_out,          m_pc);
    chk("inst",       64'(inst),       64'(m_inst));
    chk("exu_ctr",    64'(exu_ctr),    64'(m_ctr));
    chk("regWr",      64'(regWr),      64'(exp_wr));
    chk("halt",       64'(halt),       64'(m_halt));
    chk("trap",       64'(trap),       64'(m_trap));
    chk("trap_cause", 64'(trap_cause), 64'(m_cause));
    chk("retired",    retired,         m_retired);
    chk("halt_trap_excl", 64'(halt & trap), 64'd0);
    chk("pc_wrap_inst", pc_out_w,      m_pc - RPC + RPC_W);
  endtask

  task automatic do_reset(input bit with_valid);
    rst        = 1'b1;
    imem_valid = with_valid;
    imem_rdata = $urandom;
    tick();
    rst        = 1'b0;
    m_pc       = RPC;
    m_retired  = 64'd0;
    m_inst     = 32'h0;
    m_ctr      = 4'h0;
    m_halt     = 1'b0;
    m_trap     = 1'b0;
    m_cause    = 2'd0;
    noise();
    check_all(S_IDLE);
    tick();
    imem_valid = 1'b0;
  endtask

  task automatic hold_stop(input logic [2:0] st, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      noise();
      check_all(st);
      tick();
    end
    imem_valid = 1'b0;
  endtask

  // Starts in FETCH; returns in FETCH after WB, or in HALT/TRAP, or in FETCH after a reset.
  task automatic run_instr(input logic [31:0] w, input int delay, input bit rst_in_exec);
    int         kind;
    logic [3:0] ctr;
    for (int i = 0; i < delay; i++) begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      check_all(S_FETCH);
      tick();
    end
    imem_valid = 1'b1;
    imem_rdata = w;
    check_all(S_FETCH);
    tick();
    m_inst = w;
    noise();
    check_all(S_DECODE);
    classify(w, kind, ctr);
    tick();
    if (kind == 1) begin
      m_halt = 1'b1;
      hold_stop(S_HALT, 20);
    end else if (kind == 2) begin
      m_trap  = 1'b1;
      m_cause = 2'd2;
      hold_stop(S_TRAP, 5);
    end else begin
      m_ctr = ctr;
      noise();
      check_all(S_EXEC);
      if (rst_in_exec) begin
        do_reset(1'b0);
      end else begin
        tick();
        noise();
        check_all(S_WB);
        tick();
        imem_valid = 1'b0;
        m_pc      = m_pc + 64'd4;
        m_retired = m_retired + 64'd1;
      end
    end
  endtask

  task automatic run_timeout();
    for (int i = 0; i < TIMEOUT; i++) begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      check_all(S_FETCH);
      tick();
    end
    m_trap  = 1'b1;
    m_cause = 2'd1;
    hold_stop(S_TRAP, 5);
  endtask

  initial begin
    int dly;

    do_reset(1'b0);

    // single addi with immediate valid
    run_instr(32'h0050_0093, 0, 1'b0);
    chk("t1_pc", pc_out, 64'h0000_0000_8000_0004);
    chk("t1_retired", retired, 64'd1);

    // add, sub, addi x0 with delayed valid
    do_reset(1'b0);
    run_instr(32'h0020_81b3, 3, 1'b0);
    run_instr(32'h4020_81b3, 3, 1'b0);
    run_instr(32'h0000_0013, 3, 1'b0);
    chk("t2_pc", pc_out, 64'h0000_0000_8000_000C);
    chk("t2_retired", retired, 64'd3);

    // ebreak
    run_instr(32'h0010_0073, 0, 1'b0);
    chk("t3_pc", pc_out, 64'h0000_0000_8000_000C);

    // illegal all-ones word
    do_reset(1'b0);
    run_instr(32'hFFFF_FFFF, 1, 1'b0);
    chk("t4_cause", 64'(trap_cause), 64'd2);
    chk("t4_pc", pc_out, RPC);

    // fetch timeout, then reset and resume
    do_reset(1'b0);
    run_instr(32'h0050_0093, 0, 1'b0);
    run_timeout();
    chk("t5_cause", 64'(trap_cause), 64'd1);
    do_reset(1'b0);
    run_instr(32'h0050_0093, TIMEOUT - 1, 1'b0);
    chk("t5_pc", pc_out, 64'h0000_0000_8000_0004);

    // reset together with imem_valid in FETCH
    do_reset(1'b1);

    // wrap instance and reset during EXEC
    do_reset(1'b0);
    run_instr(32'h0050_0093, 0, 1'b0);
    chk("t6_pc_wrap", pc_out_w, 64'd0);
    run_instr(32'h0020_81b3, 2, 1'b1);

    // randomized programs
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 14) == 0) begin
        run_timeout();
      end else begin
        dly = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 4));
        run_instr(rand_inst(), dly, ($urandom_range(0, 19) == 0));
      end
      if (m_halt || m_trap) do_reset(1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
